// File: rtl/store_data.sv
// Store path: formats SB/SH/SW into lane-aligned entries, buffers them, drains word beats to memory.
// Latency: acceptance at edge N gives mem_req at edge N+1 when empty; split stores take two beats.
// Backpressure: st_ready drops when the buffer is full; mem_req/addr/data/strb hold until mem_ack.
module store_data #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [2:0]             st_funct3,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  output logic [$clog2(DEPTH):0] buf_count,
  output logic                   busy,
  output logic                   funct3_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [63:0]   d64;
    logic [7:0]    s8;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

  entry_t          buf_q [DEPTH];
  entry_t          fmt;
  entry_t          head;
  entry_t          nxt;
  logic            f3_legal;
  logic [3:0]      mask;
  logic [31:0]     data_t;
  logic            accept;
  logic            enq;
  logic            retire;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            err_q;

  // Decode size, truncate data and shift data/strobes into a two-word lane window
  always_comb begin
    f3_legal = 1'b1;
    mask     = 4'b1111;
    data_t   = st_data;
    case (st_funct3)
      3'b000:  begin mask = 4'b0001; data_t = {24'b0, st_data[7:0]};  end
      3'b001:  begin mask = 4'b0011; data_t = {16'b0, st_data[15:0]}; end
      3'b010:  begin mask = 4'b1111; data_t = st_data;                end
      default: f3_legal = 1'b0;
    endcase
    fmt.waddr = {st_addr[AW-1:2], 2'b00};
    fmt.d64   = {32'b0, data_t} << {st_ready & 1'b0, st_addr[1:0], 3'b000};
    fmt.s8    = {4'b0, mask} << st_addr[1:0];
  end

  // Full check uses the registered count only, so a same-cycle retire never frees a slot
  assign st_ready = (cnt_q < CW'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign enq      = accept && f3_legal;
  assign head     = buf_q[rd_ptr_q];
  assign nxt      = buf_q[rd_ptr_q + PW'(1)];

  // Entry storage; contents need no reset because pointers qualify them
  always_ff @(posedge clk) begin
    if (enq) buf_q[wr_ptr_q] <= fmt;
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = rd_ptr_q + PW'(retire);
    cnt_d    = cnt_q + CW'(enq) - CW'(retire);
  end

  // Drain FSM next state and next beat registers; a split entry stays at the head until beat 1 is acked
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = BEAT0;
          addr_d  = head.waddr;
          wdata_d = head.d64[31:0];
          wstrb_d = head.s8[3:0];
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          if (head.s8[7:4] != 4'b0) begin
            state_d = BEAT1;
            addr_d  = head.waddr + AW'(4);
            wdata_d = head.d64[63:32];
            wstrb_d = head.s8[7:4];
          end else begin
            retire = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (retire) begin
      if (cnt_q > CW'(1)) begin
        state_d = BEAT0;
        addr_d  = nxt.waddr;
        wdata_d = nxt.d64[31:0];
        wstrb_d = nxt.s8[3:0];
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, pointer and beat registers; reset abandons any beat in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      err_q    <= accept && !f3_legal;
    end
  end

  // Outputs derived from registered state
  always_comb begin
    mem_req    = (state_q != IDLE);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_wstrb  = wstrb_q;
    buf_count  = cnt_q;
    busy       = (cnt_q != '0) || (state_q != IDLE);
    funct3_err = err_q;
  end

endmodule

// File: tb/tb_store_data.sv
module tb_store_data;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  buf_count;
  logic        busy;
  logic        funct3_err;

  store_data #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
    .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .buf_count(buf_count), .busy(busy), .funct3_err(funct3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t hold_b;
  int    checks    = 0;
  int    failures  = 0;
  int    exp_count = 0;
  bit    model_on  = 0;
  bit    err_pend  = 0;
  bit    hold      = 0;
  bit    accepted  = 0;
  bit    got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the stored bytes one at a time and group them by the word they land in
  task automatic model_push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int          n;
    beat_t       b;
    logic [31:0] ba;
    logic [31:0] w;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    b = '0;
    for (int k = 0; k < n; k++) begin
      ba = a + 32'(k);
      w  = {ba[31:2], 2'b00};
      if (k > 0 && w != b.addr) begin
        exp_q.push_back(b);
        b = '0;
      end
      b.addr = w;
      b.wdata[8*ba[1:0] +: 8] = d[8*k +: 8];
      b.strb[ba[1:0]] = 1'b1;
    end
    b.last = 1'b1;
    exp_q.push_back(b);
    exp_count++;
  endtask

  task automatic step();
    beat_t b;
    @(negedge clk);
    accepted = 0;
    if (model_on) begin
      check("funct3_err", funct3_err, err_pend);
      check("buf_count", buf_count, exp_count);
      check("busy", busy, exp_count != 0);
      check("st_ready", st_ready, exp_count < DEPTH);
      if (hold) begin
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, hold_b.addr);
        check("hold_wdata", mem_wdata, hold_b.wdata);
        check("hold_wstrb", mem_wstrb, hold_b.strb);
      end
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("beat_addr", mem_addr, b.addr);
          check("beat_wdata", mem_wdata, b.wdata);
          check("beat_wstrb", mem_wstrb, b.strb);
          if (b.last) exp_count--;
        end
      end
    end
    err_pend = 0;
    hold = model_on && !reset && mem_req && !mem_ack;
    hold_b.addr  = mem_addr;
    hold_b.wdata = mem_wdata;
    hold_b.strb  = mem_wstrb;
    hold_b.last  = 1'b0;
    if (reset) begin
      exp_q.delete();
      exp_count = 0;
      model_on  = 1;
    end else if (model_on && st_valid && st_ready) begin
      accepted = 1;
      if (st_funct3 <= 3'd2) model_push(st_funct3, st_addr, st_data);
      else err_pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  task automatic drain(input int budget);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if (exp_count == 0) begin
        got = 1;
        break;
      end
      step();
    end
    if (exp_count == 0) got = 1;
    check("drain_done", got, 1);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_funct3 = 3'd0; st_addr = '0; st_data = '0; mem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_req", mem_req, 0);
    check("rst_count", buf_count, 0);
    check("rst_ready", st_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", funct3_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);

    // SB at 0x1003, ack tied high
    mem_ack = 1'b1;
    drive(3'b000, 32'h1003, 32'hAABBCCDD);
    step();
    st_valid = 1'b0;
    check("sb_acc", accepted, 1);
    check("sb_req_lat0", mem_req, 0);
    step();
    check("sb_req", mem_req, 1);
    check("sb_addr", mem_addr, 32'h1000);
    check("sb_wdata", mem_wdata, 32'hDD000000);
    check("sb_wstrb", mem_wstrb, 4'b1000);
    step();
    check("sb_done", mem_req, 0);

    // SH at 0x2002
    drive(3'b001, 32'h2002, 32'h1234BEEF);
    step();
    st_valid = 1'b0;
    step();
    check("sh_addr", mem_addr, 32'h2000);
    check("sh_wdata", mem_wdata, 32'hBEEF0000);
    check("sh_wstrb", mem_wstrb, 4'b1100);
    step();
    check("sh_done", mem_req, 0);

    // SW at 0x3001 splits across two words
    drive(3'b010, 32'h3001, 32'h11223344);
    step();
    st_valid = 1'b0;
    step();
    check("sw_b0_addr", mem_addr, 32'h3000);
    check("sw_b0_wdata", mem_wdata, 32'h22334400);
    check("sw_b0_wstrb", mem_wstrb, 4'b1110);
    step();
    check("sw_b1_req", mem_req, 1);
    check("sw_b1_addr", mem_addr, 32'h3004);
    check("sw_b1_wdata", mem_wdata, 32'h00000011);
    check("sw_b1_wstrb", mem_wstrb, 4'b0001);
    step();
    check("sw_done", mem_req, 0);

    // SH at 0x4003 splits
    drive(3'b001, 32'h4003, 32'h00005566);
    step();
    st_valid = 1'b0;
    step();
    check("shx_b0_addr", mem_addr, 32'h4000);
    check("shx_b0_wdata", mem_wdata, 32'h66000000);
    check("shx_b0_wstrb", mem_wstrb, 4'b1000);
    step();
    check("shx_b1_addr", mem_addr, 32'h4004);
    check("shx_b1_wdata", mem_wdata, 32'h00000055);
    check("shx_b1_wstrb", mem_wstrb, 4'b0001);
    step();

    // Fill the buffer with ack held low
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, 32'(4 * i), 32'hC0DE0000 + 32'(i));
      step();
    end
    check("full_count", buf_count, 4);
    check("full_ready", st_ready, 0);
    check("full_req", mem_req, 1);
    check("full_addr", mem_addr, 32'h0);
    drive(3'b010, 32'h10, 32'hC0DE0004);
    step();
    check("full_5th_blocked", accepted, 0);
    step();
    check("full_hold_addr", mem_addr, 32'h0);
    check("full_hold_wdata", mem_wdata, 32'hC0DE0000);
    mem_ack = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) begin
        got = 1;
        break;
      end
    end
    st_valid = 1'b0;
    check("full_5th_acc", got, 1);
    drain(40);
    check("full_busy_off", busy, 0);
    check("full_q_empty", exp_q.size(), 0);

    // Illegal funct3
    drive(3'b011, 32'h5000, 32'h12345678);
    step();
    st_valid = 1'b0;
    check("ill_acc", accepted, 1);
    check("ill_err", funct3_err, 1);
    check("ill_req", mem_req, 0);
    step();
    check("ill_err_once", funct3_err, 0);
    check("ill_no_req", mem_req, 0);
    check("ill_count", buf_count, 0);

    // Reset while beat 0 of a split SW is outstanding
    mem_ack = 1'b0;
    drive(3'b010, 32'h3001, 32'h11223344);
    step();
    st_valid = 1'b0;
    step();
    check("mid_req", mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_count", buf_count, 0);
    check("mid_rst_ready", st_ready, 1);
    check("mid_rst_wstrb", mem_wstrb, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("mid_no_beat1", mem_req, 0);

    // Randomized traffic against the byte-level model
    for (int i = 0; i < 600; i++) begin
      st_valid  = ($urandom_range(0, 2) != 0);
      st_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      st_addr   = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom();
      st_data   = $urandom();
      mem_ack   = ($urandom_range(0, 3) != 0);
      step();
    end
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    drain(100);
    check("rand_q_empty", exp_q.size(), 0);
    check("rand_busy_off", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_data.md
Name: store_data

Overview:
- MEM-stage store path of the pipelined RV32I core. It is the write-side counterpart of the WB-stage load extraction.
- Accepts SB/SH/SW requests carrying the effective address and rs2 data.
- Aligns data into byte lanes and generates byte strobes.
- Buffers stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Splits stores that cross a word boundary into two word-aligned beats.

Parameters:
- DEPTH, 4, number of store-buffer entries (power of 2, ≥2).
- AW, 32, address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request valid this cycle.
- st_ready  out  1  buffer can accept a request; a store is accepted on st_valid && st_ready.
- st_funct3  in  3  000=SB, 001=SH, 010=SW.
- st_addr  in  AW  byte address (EX-stage ALU result).
- st_data  in  32  rs2 value, unaligned (LSB-justified).
- mem_req  out  1  write beat valid.
- mem_ack  in  1  memory accepted the beat this cycle.
- mem_addr  out  AW  word-aligned address; bits [1:0] are always 00.
- mem_wdata  out  32  lane-aligned write data.
- mem_wstrb  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- buf_count  out  $clog2(DEPTH)+1  number of occupied entries.
- busy  out  1  asserted when buf_count≠0 or the drain FSM is not IDLE. The hazard unit stalls loads while busy=1.
- funct3_err  out  1  one-cycle pulse when an illegal funct3 is accepted.

Behaviour:
- Reset (synchronous, active high, dominates all other inputs):
  - FIFO pointers and count go to 0, FSM goes to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, funct3_err=0, busy=0, buf_count=0.
  - st_ready=1 from the first cycle after reset.
  - Reset mid-drain abandons the beat; no second beat is issued.
- Enqueue formatting (combinational at acceptance; the result is stored in the entry):
  - off = st_addr[1:0].
  - mask = 0001 for SB, 0011 for SH, 1111 for SW; data is truncated to 8/16/32 bits.
  - d64 = {32'b0, data} << (8*off).
  - s8 = {4'b0, mask} << off.
  - The entry holds {word_addr = st_addr & ~3, d64, s8}.
- Illegal funct3:
  - The request is still accepted (st_ready handshake completes) but is not enqueued.
  - funct3_err pulses the following cycle.
- st_ready = (buf_count < DEPTH).
  - It is based on registered count only; a dequeue in the same cycle does not free a slot for a same-cycle enqueue.
- Simultaneous enqueue and entry retire (not full): buf_count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- Drain FSM states:
  - IDLE:
    - If buf_count≠0, present the head beat 0 and go to BEAT0.
    - Beat 0: mem_req=1, mem_addr=word_addr, mem_wdata=d64[31:0], mem_wstrb=s8[3:0].
  - BEAT0, holding mem_req until mem_ack:
    - On ack with s8[7:4]≠0: go to BEAT1.
    - On ack with s8[7:4]=0: retire the entry. If another entry is present, load its beat 0 and stay in BEAT0; otherwise go to IDLE with mem_req=0.
  - BEAT1:
    - Beat 1: mem_req=1, mem_addr=word_addr+4 (wraps modulo 2^AW), mem_wdata=d64[63:32], mem_wstrb=s8[7:4].
    - On ack: retire the entry, then go to BEAT0 or IDLE by the same rule as BEAT0.
- Handshake rules:
  - mem_addr, mem_wdata and mem_wstrb are registered and held stable while mem_req=1 && mem_ack=0.
  - mem_ack while mem_req=0 is ignored.
  - One beat is issued per ack; back-to-back beats are allowed with no idle cycle.
- Latency:
  - Acceptance at edge N gives the earliest mem_req=1 in cycle N+1, when the buffer and FSM were empty.
- Ordering:
  - Strict program order; both beats of a split store complete before the next entry starts.

Test Plan:
- SB at addr 0x1003, data 0xAABBCCDD, mem_ack tied high -> one beat: mem_addr=0x1000, wdata=0xDD000000, wstrb=1000, appearing 1 cycle after acceptance.
- SH at addr 0x2002, data 0x1234BEEF -> one beat: addr 0x2000, wdata=0xBEEF0000, wstrb=1100.
- SW at addr 0x3001, data 0x11223344 -> beat 0: addr 0x3000, wdata=0x22334400, wstrb=1110; beat 1: addr 0x3004, wdata=0x00000011, wstrb=0001.
- SH at 0x4003, data 0x5566 -> beat 0: addr 0x4000, wdata=0x66000000, wstrb=1000; beat 1: addr 0x4004, wdata=0x00000055, wstrb=0001.
- Backpressure/full case:
  - Stimulus: mem_ack=0, then 5 SW requests to 0x0, 0x4, 0x8, 0xC, 0x10.
  - Required: st_ready drops after the 4th acceptance; buf_count=4; mem_req outputs held stable.
  - Release: raise mem_ack -> four beats in order, busy=0 one cycle after the last ack, and the 5th request is accepted once st_ready=1.
- Reset and illegal funct3:
  - funct3=011 -> funct3_err pulses once and no mem_req.
  - Reset asserted during BEAT0 of a split SW -> next cycle mem_req=0, buf_count=0, st_ready=1.
